// File: rtl/hazard_stall_unit_pkg.sv
// Shared encodings for the hazard stall unit: NPC control codes, FSM states,
// stall-depth values and the redirect-class helper.
package hazard_stall_unit_pkg;

   localparam logic [2:0] NPC_PLUS4  = 3'b000;
   localparam logic [2:0] NPC_BRANCH = 3'b001;
   localparam logic [2:0] NPC_JUMP   = 3'b010;
   localparam logic [2:0] NPC_JALR   = 3'b100;

   typedef enum logic {
      HS_RUN  = 1'b0,
      HS_HOLD = 1'b1
   } hs_state_e;

   localparam logic [1:0] NEED_NONE = 2'd0;
   localparam logic [1:0] NEED_ONE  = 2'd1;
   localparam logic [1:0] NEED_TWO  = 2'd2;

   // Branches and JALR resolve in ID, so their operands must be ready a stage early.
   function automatic logic is_id_resolved(input logic [2:0] npc_op);
      return (npc_op == NPC_BRANCH) || (npc_op == NPC_JALR);
   endfunction

endpackage

// File: rtl/hazard_stall_unit_need_calc.sv
// Combinational stall-depth calculation: how many cycles the ID instruction
// must wait before every operand it reads reaches a bypass point.
module hazard_need_calc
   import hazard_stall_unit_pkg::*;
(
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       use_rs1,
   input  logic       use_rs2,
   input  logic [2:0] NPCOp,
   input  logic [4:0] ID_EX_rd,
   input  logic       ID_EX_RegWrite,
   input  logic       ID_EX_MemRead,
   input  logic [4:0] EX_MEM_rd,
   input  logic       EX_MEM_MemRead,
   output logic [1:0] need
);

   function automatic logic [1:0] src_need(
      input logic       use_src,
      input logic [4:0] src,
      input logic       is_br,
      input logic [4:0] ex_rd,
      input logic       ex_regwrite,
      input logic       ex_memread,
      input logic [4:0] mem_rd,
      input logic       mem_memread
   );
      logic ex_hit;
      logic mem_hit;
      logic [1:0] res;
      ex_hit  = use_src && (ex_rd != 5'd0) && (ex_rd == src) && (ex_regwrite || ex_memread);
      mem_hit = use_src && (mem_rd != 5'd0) && (mem_rd == src) && mem_memread;
      res = NEED_NONE;
      if (is_br) begin
         if (ex_hit && ex_memread) begin
            res = NEED_TWO;
         end else if (ex_hit || mem_hit) begin
            res = NEED_ONE;
         end else begin
            res = NEED_NONE;
         end
      end else begin
         if (ex_hit && ex_memread) begin
            res = NEED_ONE;
         end else begin
            res = NEED_NONE;
         end
      end
      return res;
   endfunction

   logic       is_br_s;
   logic [1:0] need_rs1_s;
   logic [1:0] need_rs2_s;

   assign is_br_s = is_id_resolved(NPCOp);

   // Per-source depth, then the larger of the two; rs1==rs2 collapses naturally.
   always_comb begin
      need_rs1_s = src_need(use_rs1, rs1, is_br_s, ID_EX_rd, ID_EX_RegWrite, ID_EX_MemRead,
                            EX_MEM_rd, EX_MEM_MemRead);
      need_rs2_s = src_need(use_rs2, rs2, is_br_s, ID_EX_rd, ID_EX_RegWrite, ID_EX_MemRead,
                            EX_MEM_rd, EX_MEM_MemRead);
      if (need_rs1_s > need_rs2_s) begin
         need = need_rs1_s;
      end else begin
         need = need_rs2_s;
      end
   end

endmodule

// File: rtl/hazard_stall_unit.sv
// Front-end stall controller: holds PC and IF/ID, bubbles ID/EX for as many
// cycles as the operand hazard needs, and flushes IF/ID on a taken redirect.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic             use_rs1,
   input  logic             use_rs2,
   input  logic [2:0]       NPCOp,
   input  logic [4:0]       ID_EX_rd,
   input  logic             ID_EX_RegWrite,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       EX_MEM_rd,
   input  logic             EX_MEM_MemRead,
   input  logic             branch_taken,
   output logic             PC_write,
   output logic             IF_ID_write,
   output logic             IF_ID_flush,
   output logic             ID_EX_bubble,
   output logic             stall_active,
   output logic [CNT_W-1:0] stall_cycles
);

   hs_state_e        state_r;
   logic             cnt_r;
   logic [1:0]       need_s;
   logic             stall_s;
   logic [CNT_W-1:0] stall_cycles_r;

   hazard_need_calc u_need (
      .rs1            (rs1),
      .rs2            (rs2),
      .use_rs1        (use_rs1),
      .use_rs2        (use_rs2),
      .NPCOp          (NPCOp),
      .ID_EX_rd       (ID_EX_rd),
      .ID_EX_RegWrite (ID_EX_RegWrite),
      .ID_EX_MemRead  (ID_EX_MemRead),
      .EX_MEM_rd      (EX_MEM_rd),
      .EX_MEM_MemRead (EX_MEM_MemRead),
      .need           (need_s)
   );

   // HOLD stalls regardless of detection; RUN stalls only while a hazard is seen.
   assign stall_s = (state_r == HS_HOLD) || (need_s != NEED_NONE);

   // Stall FSM: a two-cycle need spends its first cycle in RUN and its second in HOLD.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= HS_RUN;
         cnt_r   <= 1'b0;
      end else begin
         case (state_r)
            HS_RUN: begin
               if (need_s == NEED_TWO) begin
                  state_r <= HS_HOLD;
                  cnt_r   <= 1'b1;
               end else begin
                  state_r <= HS_RUN;
                  cnt_r   <= 1'b0;
               end
            end
            HS_HOLD: begin
               cnt_r <= cnt_r - 1'b1;
               if (cnt_r == 1'b1) begin
                  state_r <= HS_RUN;
               end else begin
                  state_r <= HS_HOLD;
               end
            end
            default: begin
               state_r <= HS_RUN;
               cnt_r   <= 1'b0;
            end
         endcase
      end
   end

   // Mealy output mux; a redirect seen during a stall is ignored.
   always_comb begin
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      ID_EX_bubble = 1'b0;
      stall_active = 1'b0;
      IF_ID_flush  = 1'b0;
      if (stall_s) begin
         PC_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_bubble = 1'b1;
         stall_active = 1'b1;
         IF_ID_flush  = 1'b0;
      end else begin
         IF_ID_flush  = branch_taken;
      end
   end

   // Saturating stall-cycle performance counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cycles_r <= {CNT_W{1'b0}};
      end else if (stall_s && (stall_cycles_r != {CNT_W{1'b1}})) begin
         stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cycles_r <= stall_cycles_r;
      end
   end

   assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: hand-computed expectations for each
// hazard class, the two-cycle hold, redirect flush, reset and counter saturation.
module tb_hazard_stall_unit;
   import hazard_stall_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic [4:0]  rs1, rs2, ID_EX_rd, EX_MEM_rd;
   logic        use_rs1, use_rs2, ID_EX_RegWrite, ID_EX_MemRead, EX_MEM_MemRead, branch_taken;
   logic [2:0]  NPCOp;
   logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, stall_active;
   logic [15:0] stall_cycles;
   logic        s_PC_write, s_IF_ID_write, s_IF_ID_flush, s_ID_EX_bubble, s_stall_active;
   logic [2:0]  s_stall_cycles;

   int checks   = 0;
   int failures = 0;

   localparam logic [4:0] RUNV  = 5'b11000;
   localparam logic [4:0] STALL = 5'b00011;
   localparam logic [4:0] FLUSH = 5'b11100;

   always #5 clk = ~clk;

   hazard_stall_unit dut (
      .clk(clk), .rstn(rstn), .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
      .NPCOp(NPCOp), .ID_EX_rd(ID_EX_rd), .ID_EX_RegWrite(ID_EX_RegWrite),
      .ID_EX_MemRead(ID_EX_MemRead), .EX_MEM_rd(EX_MEM_rd), .EX_MEM_MemRead(EX_MEM_MemRead),
      .branch_taken(branch_taken), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
      .IF_ID_flush(IF_ID_flush), .ID_EX_bubble(ID_EX_bubble), .stall_active(stall_active),
      .stall_cycles(stall_cycles)
   );

   hazard_stall_unit #(.CNT_W(3)) sat_dut (
      .clk(clk), .rstn(rstn), .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
      .NPCOp(NPCOp), .ID_EX_rd(ID_EX_rd), .ID_EX_RegWrite(ID_EX_RegWrite),
      .ID_EX_MemRead(ID_EX_MemRead), .EX_MEM_rd(EX_MEM_rd), .EX_MEM_MemRead(EX_MEM_MemRead),
      .branch_taken(branch_taken), .PC_write(s_PC_write), .IF_ID_write(s_IF_ID_write),
      .IF_ID_flush(s_IF_ID_flush), .ID_EX_bubble(s_ID_EX_bubble), .stall_active(s_stall_active),
      .stall_cycles(s_stall_cycles)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {27'd0, PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, stall_active};
   endfunction

   task automatic clear();
      rs1 = 5'd0; rs2 = 5'd0; use_rs1 = 1'b0; use_rs2 = 1'b0; NPCOp = NPC_PLUS4;
      ID_EX_rd = 5'd0; ID_EX_RegWrite = 1'b0; ID_EX_MemRead = 1'b0;
      EX_MEM_rd = 5'd0; EX_MEM_MemRead = 1'b0; branch_taken = 1'b0;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0;
      clear();
      #2;
      chk("reset_outs", outs(), {27'd0, RUNV});
      chk("reset_cnt", {16'd0, stall_cycles}, 32'd0);
      chk("reset_sat_cnt", {29'd0, s_stall_cycles}, 32'd0);
      tick();
      rstn = 1'b1;

      // load-use: lw x5 in EX, add reads x5
      tick(); clear();
      ID_EX_rd = 5'd5; ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1; rs1 = 5'd5; use_rs1 = 1'b1;
      #1 chk("loaduse_stall", outs(), {27'd0, STALL});
      tick(); clear();
      rs1 = 5'd5; use_rs1 = 1'b1; EX_MEM_rd = 5'd5; EX_MEM_MemRead = 1'b1;
      #1 chk("loaduse_release", outs(), {27'd0, RUNV});
      chk("loaduse_cnt", {16'd0, stall_cycles}, 32'd1);

      // addi x6 in EX, beq reads x6 on rs2
      tick(); clear();
      ID_EX_rd = 5'd6; ID_EX_RegWrite = 1'b1; rs2 = 5'd6; use_rs2 = 1'b1; NPCOp = NPC_BRANCH;
      #1 chk("alu_br_stall", outs(), {27'd0, STALL});
      tick(); clear();
      rs2 = 5'd6; use_rs2 = 1'b1; NPCOp = NPC_BRANCH; EX_MEM_rd = 5'd6;
      #1 chk("alu_br_release", outs(), {27'd0, RUNV});
      chk("alu_br_cnt", {16'd0, stall_cycles}, 32'd2);

      // lw x7 in EX, jalr reads x7: two cycles, second held with no hazard and a redirect
      tick(); clear();
      ID_EX_rd = 5'd7; ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1;
      rs1 = 5'd7; use_rs1 = 1'b1; NPCOp = NPC_JALR;
      #1 chk("ld_jalr_stall1", outs(), {27'd0, STALL});
      tick(); clear();
      branch_taken = 1'b1;
      #1 chk("ld_jalr_hold_noflush", outs(), {27'd0, STALL});
      tick(); clear();
      #1 chk("ld_jalr_release", outs(), {27'd0, RUNV});
      chk("ld_jalr_cnt", {16'd0, stall_cycles}, 32'd4);

      // x0 never stalls; unused source never stalls
      clear();
      ID_EX_rd = 5'd0; ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1;
      rs1 = 5'd0; use_rs1 = 1'b1; NPCOp = NPC_BRANCH;
      #1 chk("x0_no_stall", outs(), {27'd0, RUNV});
      clear();
      ID_EX_rd = 5'd5; ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1; rs2 = 5'd5; use_rs2 = 1'b0;
      #1 chk("unused_rs2_no_stall", outs(), {27'd0, RUNV});
      clear();
      ID_EX_rd = 5'd3; rs1 = 5'd3; use_rs1 = 1'b1; NPCOp = NPC_BRANCH;
      #1 chk("no_write_no_stall", outs(), {27'd0, RUNV});

      // rs1==rs2 load-use: one stall only
      tick(); clear();
      ID_EX_rd = 5'd9; ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1;
      rs1 = 5'd9; rs2 = 5'd9; use_rs1 = 1'b1; use_rs2 = 1'b1;
      #1 chk("same_src_stall", outs(), {27'd0, STALL});
      tick(); clear();
      #1 chk("same_src_release", outs(), {27'd0, RUNV});
      chk("same_src_cnt", {16'd0, stall_cycles}, 32'd5);

      // branch on a load sitting in MEM: one stall
      clear();
      EX_MEM_rd = 5'd8; EX_MEM_MemRead = 1'b1; rs1 = 5'd8; use_rs1 = 1'b1; NPCOp = NPC_BRANCH;
      #1 chk("mem_ld_br_stall", outs(), {27'd0, STALL});
      tick(); clear();
      #1 chk("mem_ld_br_release", outs(), {27'd0, RUNV});
      chk("mem_ld_br_cnt", {16'd0, stall_cycles}, 32'd6);

      // taken redirect with no hazard flushes for that cycle only
      branch_taken = 1'b1;
      #1 chk("flush_run", outs(), {27'd0, FLUSH});
      tick(); clear();
      #1 chk("flush_drop", outs(), {27'd0, RUNV});

      // reset during the HOLD cycle
      tick(); clear();
      ID_EX_rd = 5'd7; ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1;
      rs1 = 5'd7; use_rs1 = 1'b1; NPCOp = NPC_JALR;
      #1 chk("rst_hold_stall1", outs(), {27'd0, STALL});
      tick(); clear();
      #1 chk("rst_hold_in_hold", outs(), {27'd0, STALL});
      rstn = 1'b0;
      #1 chk("rst_hold_outs", outs(), {27'd0, RUNV});
      chk("rst_hold_cnt", {16'd0, stall_cycles}, 32'd0);
      chk("rst_hold_sat_cnt", {29'd0, s_stall_cycles}, 32'd0);
      #1 rstn = 1'b1;
      tick();
      #1 chk("rst_hold_run", outs(), {27'd0, RUNV});
      chk("rst_hold_cnt_idle", {16'd0, stall_cycles}, 32'd0);

      // continuous load-use: the 3-bit counter saturates at 7
      clear();
      ID_EX_rd = 5'd4; ID_EX_RegWrite = 1'b1; ID_EX_MemRead = 1'b1; rs1 = 5'd4; use_rs1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
      end
      #1 chk("sat_stall", outs(), {27'd0, STALL});
      chk("sat_main_cnt", {16'd0, stall_cycles}, 32'd10);
      chk("sat_small_cnt", {29'd0, s_stall_cycles}, 32'd7);
      tick();
      chk("sat_small_hold", {29'd0, s_stall_cycles}, 32'd7);
      clear();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer side of the operand-bypass scheme. It detects hazards that forwarding cannot cover in the current cycle and stalls the front end until the needed value reaches a bypass point.
- Covers load-use in EX, and ID-stage branch/JALR operands that depend on an ALU result or a load still in flight.
- Inserts bubbles into ID/EX and flushes IF/ID on a taken redirect.
- Sits beside the forwarding unit; its inputs come from the IF/ID, ID/EX and EX/MEM pipeline registers.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock
- rstn  in  1  asynchronous active-low reset
- rs1  in  5  IF/ID rs1 field of the instruction in ID
- rs2  in  5  IF/ID rs2 field of the instruction in ID
- use_rs1  in  1  the ID instruction reads rs1
- use_rs2  in  1  the ID instruction reads rs2
- NPCOp  in  3  NPC control of the ID instruction (`NPC_* codes from ctrl_encode_def.v)
- ID_EX_rd  in  5  destination register in EX
- ID_EX_RegWrite  in  1  EX instruction writes a register
- ID_EX_MemRead  in  1  EX instruction is a load
- EX_MEM_rd  in  5  destination register in MEM
- EX_MEM_MemRead  in  1  MEM instruction is a load
- branch_taken  in  1  ID-stage redirect resolved taken (branch/jal/jalr)
- PC_write  out  1  PC update enable
- IF_ID_write  out  1  IF/ID register enable
- IF_ID_flush  out  1  IF/ID register clear
- ID_EX_bubble  out  1  load NOP control into ID/EX
- stall_active  out  1  a stall cycle is in progress
- stall_cycles  out  CNT_W  saturating count of stall cycles since reset

Behaviour:
- Reset (rstn low, asynchronous, any time, including mid-stall):
  - state=RUN, cnt=0, stall_cycles=0.
  - Outputs settle to PC_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0, stall_active=0.
  - A stall in progress is abandoned.
- Derived signals:
  - is_br = (NPCOp==`NPC_BRANCH || NPCOp==`NPC_JALR).
  - ex_hit_x = use_x && ID_EX_rd!=0 && ID_EX_rd==x && (ID_EX_RegWrite || ID_EX_MemRead).
  - mem_hit_x = use_x && EX_MEM_rd!=0 && EX_MEM_rd==x && EX_MEM_MemRead.
- need (2 bits), evaluated per source register; the maximum over rs1 and rs2 is taken:
  - is_br && ex_hit && ID_EX_MemRead -> 2 (load must reach MEM/WB).
  - is_br && ex_hit && !ID_EX_MemRead -> 1 (ALU result must reach EX/MEM).
  - is_br && mem_hit -> 1.
  - !is_br && ex_hit && ID_EX_MemRead -> 1 (classic load-use).
  - Otherwise 0.
- FSM with states RUN and HOLD and a 1-bit cnt:
  - RUN, need==0: no stall.
  - RUN, need>=1: stall this cycle (outputs are Mealy, combinational on need). If need==2, go to HOLD with cnt=1; otherwise stay in RUN.
  - HOLD: stall unconditionally and ignore detection. cnt decrements; when cnt==1 at the clock edge, return to RUN.
- Stall cycle outputs: PC_write=0, IF_ID_write=0, ID_EX_bubble=1, stall_active=1.
- IF_ID_flush = branch_taken && !stall_active. A redirect never coincides with a stall, because a stalled branch's operands are not valid; any branch_taken during a stall is ignored.
- stall_cycles increments on every clock edge where stall_active=1 and saturates at all-ones.
- Latency: the decision is visible in the same cycle as the inputs. The total stall is exactly need cycles; no extra cycles are added.
- x0 never causes a stall. When rs1==rs2, the hazard is counted once, with no double stall.

Decomposition:
- State encodings (HS_RUN, HS_HOLD) go in ctrl_encode_def.v next to the `NPC_* codes.
- One natural combinational sub-module, hazard_need_calc: computes need from the register fields and control bits. The top module holds the FSM, cnt, the output mux and the performance counter.

Test Plan:
- lw x5 in EX (ID_EX_rd=5, MemRead=1); add in ID reads rs1=5, NPCOp=`NPC_PLUS4 -> 1 stall cycle (PC_write=0, ID_EX_bubble=1), then RUN; stall_cycles=1.
- addi x6 in EX (RegWrite=1, MemRead=0); beq in ID with rs2=6, NPCOp=`NPC_BRANCH -> exactly 1 stall cycle.
- lw x7 in EX; jalr in ID with rs1=7 -> 2 consecutive stall cycles. HOLD is entered in cycle 2 even if the inputs are changed to no-hazard. stall_cycles advances by 2.
- ID_EX_rd=0 with RegWrite=1, and rs1=0 with use_rs1=1 on a branch -> no stall. Separately, use_rs2=0 with a matching rs2 -> no stall.
- branch_taken=1 during HOLD -> IF_ID_flush=0. branch_taken=1 in RUN with need=0 -> IF_ID_flush=1 for that cycle.
- Drop rstn in the first HOLD cycle -> outputs return to no-stall immediately, state=RUN, stall_cycles=0. Separately, preload the counter near all-ones and stall -> it holds at all-ones.
